serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes a − b at one bit per clock, using a single full-adder cell with b inverted and an initial carry-in of 1.
- Operands arrive on a start valid/ready handshake; the result leaves on a result valid/ready handshake.
- Acts as the sequential inverse companion to the team's combinational full adder, for area-constrained datapaths that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands a/b valid
- start_ready  output  1  block idle and can accept operands
- a  input  WIDTH  minuend, sampled only on the start handshake
- b  input  WIDTH  subtrahend, sampled only on the start handshake
- busy  output  1  operation in progress (SHIFT state)
- result_valid  output  1  difference/borrowout/overflow valid
- result_ready  input  1  consumer accepts the result
- difference  output  WIDTH  a − b modulo 2^WIDTH
- borrowout  output  1  unsigned borrow, 1 when a < b (unsigned)
- overflow  output  1  signed overflow of a − b

Behaviour:
- Reset (reset_n low, asynchronous, effective immediately):
  - state = IDLE.
  - start_ready = 1 after reset, including during it.
  - busy = 0, result_valid = 0.
  - difference = 0, borrowout = 0, overflow = 0.
  - Internal operand/shift registers, bit counter and carry all cleared.
- States:
  - IDLE: start_ready = 1. On a rising edge with start_valid = 1:
    - latch a and ~b into shift registers;
    - carry = 1, count = 0;
    - go to SHIFT.
  - SHIFT: busy = 1, start_ready = 0. Each cycle processes bit i = count:
    - s = a[i] ^ ~b[i] ^ carry;
    - carry_next = majority(a[i], ~b[i], carry);
    - s is shifted into difference from the MSB side, LSB first;
    - count increments.
  - Transition SHIFT→DONE on the edge that processes i = WIDTH−1. On that edge:
    - borrowout = ~carry_next;
    - overflow = carry into MSB XOR carry out of MSB.
  - DONE:
    - result_valid = 1; start_ready = 0; busy = 0.
    - difference, borrowout and overflow are held stable.
    - On an edge with result_ready = 1: go to IDLE and clear result_valid.
    - difference, borrowout and overflow keep their values until the next DONE; the consumer must not rely on them outside result_valid.
- Latency:
  - result_valid rises exactly WIDTH clocks after the start-accept edge.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH shift cycles, one DONE cycle with result_ready already high, then IDLE.
- No same-cycle restart:
  - a start is never accepted in DONE, even when result_ready = 1;
  - start_valid outside IDLE is ignored, and a/b are not re-sampled.
- Changes on a/b after the accept edge have no effect on the result.
- result_ready in IDLE or SHIFT is ignored.
- Reset asserted in SHIFT or DONE aborts the operation; the in-flight result is discarded and not delivered.
- No combinational path from any input to any output; all outputs are registered.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, start pulse, result_ready=1 → result_valid exactly 8 cycles after accept; difference=0x02, borrowout=0, overflow=0; start_ready returns to 1 one cycle after the result handshake.
- a=0x03, b=0x05 → difference=0xFE, borrowout=1, overflow=0. Then a=0x00, b=0x00 → difference=0x00, borrowout=0, overflow=0.
- a=0x80, b=0x01 → difference=0x7F, borrowout=0, overflow=1. Then a=0x7F, b=0xFF → difference=0x80, borrowout=1, overflow=1.
- Backpressure and busy checks:
  - Hold result_ready=0 for 5 cycles in DONE → result_valid stays 1 and outputs stay stable; start_ready=0.
  - Pulse start_valid with a=0x11, b=0x22 during DONE and during SHIFT → ignored; the later delivered result still matches the originally latched operands.
- Change a/b every cycle during SHIFT after accepting a=0x40, b=0x10 → difference=0x30, borrowout=0, overflow=0.
- Drop reset_n asynchronously mid-cycle on the 3rd SHIFT cycle → busy, result_valid, difference, borrowout and overflow go to 0 immediately, with no result delivered. After release, start_ready=1 and a fresh a=0x09, b=0x04 yields difference=0x05.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, one bit per clock,
// built from one full-adder cell fed with ~b and an initial carry of 1.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] difference,
   output logic             borrowout,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] nb_q;
   logic [WIDTH-1:0] diff_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             rdy_q;
   logic             busy_q;
   logic             vld_q;
   logic             bo_q;
   logic             ovf_q;

   logic             s_d;
   logic             carry_d;
   logic             last_d;

   // Full-adder cell on the current LSBs of the operand shifters
   always_comb begin
      s_d     = a_q[0] ^ nb_q[0] ^ carry_q;
      carry_d = (a_q[0] & nb_q[0]) |
                (a_q[0] & carry_q) |
                (nb_q[0] & carry_q);
      last_d  = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         nb_q    <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         vld_q   <= 1'b0;
         bo_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_valid) begin
                  a_q     <= a;
                  nb_q    <= ~b;
                  carry_q <= 1'b1;
                  cnt_q   <= '0;
                  rdy_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               a_q     <= {1'b0, a_q[WIDTH-1:1]};
               nb_q    <= {1'b0, nb_q[WIDTH-1:1]};
               diff_q  <= {s_d, diff_q[WIDTH-1:1]};
               carry_q <= carry_d;
               cnt_q   <= cnt_q + 1'b1;
               if (last_d) begin
                  // carry_q is the carry into the MSB here
                  bo_q    <= ~carry_d;
                  ovf_q   <= carry_q ^ carry_d;
                  busy_q  <= 1'b0;
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (result_ready) begin
                  vld_q   <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               vld_q   <= 1'b0;
               rdy_q   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign start_ready  = rdy_q;
   assign busy         = busy_q;
   assign result_valid = vld_q;
   assign difference   = diff_q;
   assign borrowout    = bo_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued at
// accept time and popped by an independent monitor on each result handshake.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         reset_n;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         result_valid;
   logic         result_ready;
   logic [W-1:0] difference;
   logic         borrowout;
   logic         overflow;

   typedef struct {
      logic [W-1:0] diff;
      logic         bo;
      logic         ovf;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   prev_v = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_valid  (start_valid),
      .start_ready  (start_ready),
      .a            (a),
      .b            (b),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .difference   (difference),
      .borrowout    (borrowout),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", nm, act, exp,
                  $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the operands
   function automatic exp_t model(input int unsigned x, input int unsigned y);
      exp_t e;
      int sx, sy, sd;
      e.diff = W'((x - y) & ((1 << W) - 1));
      e.bo   = (x < y);
      sx = (x >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
      sy = (y >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
      sd = sx - sy;
      e.ovf = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
      e.acc = 0;
      return e;
   endfunction

   // Monitor: latency on valid rise, value check on each handshake
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_v = 1'b0;
      end else begin
         if (result_valid && !prev_v) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_result: got diff 0x%0h with empty queue",
                        difference);
            end else begin
               chk("latency", cyc - sb[0].acc, W);
            end
         end
         if (result_valid && result_ready && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("difference", difference, e.diff);
            chk("borrowout", borrowout, e.bo);
            chk("overflow", overflow, e.ovf);
         end
         prev_v = result_valid;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_);
      bit ok;
      exp_t e;
      ok = 0;
      start_valid = 1'b1;
      a = ta;
      b = tb_;
      for (int i = 0; i < 50; i++) begin
         if (start_ready) begin
            step();
            e = model(ta, tb_);
            e.acc = cyc;
            sb.push_back(e);
            ok = 1;
            break;
         end
         step();
      end
      start_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: got no start handshake, need one");
      end
   endtask

   // rnd=1 randomizes result_ready; a/b are scrambled every cycle
   task automatic wait_result(input bit rnd);
      bit ok, hs, rr;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         rr = rnd ? 1'($urandom) : 1'b1;
         result_ready = rr;
         hs = result_valid && rr;
         a = W'($urandom);
         b = W'($urandom);
         step();
         if (hs) begin
            ok = 1;
            break;
         end
      end
      result_ready = 1'b0;
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL result_timeout: got no result handshake, need one");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      bit seen;
      reset_n = 1'b0;
      start_valid = 1'b0;
      result_ready = 1'b0;
      a = '0;
      b = '0;
      #12;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_diff", difference, 0);
      chk("rst_bo", borrowout, 0);
      chk("rst_ovf", overflow, 0);
      step();
      reset_n = 1'b1;
      step();

      // Basic case and handshake return to IDLE
      start_op(8'h05, 8'h03);
      chk("shift_busy", busy, 1);
      chk("shift_start_ready", start_ready, 0);
      wait_result(0);
      chk("post_hs_start_ready", start_ready, 1);
      chk("post_hs_valid", result_valid, 0);

      start_op(8'h03, 8'h05);
      wait_result(0);
      start_op(8'h00, 8'h00);
      wait_result(0);
      start_op(8'h80, 8'h01);
      wait_result(0);
      start_op(8'h7F, 8'hFF);
      wait_result(0);

      // Backpressure plus ignored starts in SHIFT and DONE
      start_op(8'h21, 8'h13);
      step();
      step();
      start_valid = 1'b1;
      a = 8'h11;
      b = 8'h22;
      step();
      start_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (result_valid) begin
            seen = 1;
            break;
         end
         step();
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL bp_timeout: got result_valid 0, need 1");
      end
      e = model(8'h21, 8'h13);
      for (int i = 0; i < 5; i++) begin
         start_valid = (i == 2);
         a = 8'h11;
         b = 8'h22;
         chk("bp_valid", result_valid, 1);
         chk("bp_start_ready", start_ready, 0);
         chk("bp_busy", busy, 0);
         chk("bp_diff", difference, e.diff);
         chk("bp_bo", borrowout, e.bo);
         step();
      end
      start_valid = 1'b0;
      chk("bp_sb_pending", sb.size(), 1);
      wait_result(0);

      // Operands toggling during SHIFT
      start_op(8'h40, 8'h10);
      wait_result(0);

      // Asynchronous reset in the third SHIFT cycle
      start_op(8'h55, 8'h0F);
      step();
      step();
      #1;
      reset_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_valid", result_valid, 0);
      chk("abort_diff", difference, 0);
      chk("abort_bo", borrowout, 0);
      chk("abort_ovf", overflow, 0);
      chk("abort_start_ready", start_ready, 1);
      if (sb.size() != 0) void'(sb.pop_back());
      step();
      step();
      reset_n = 1'b1;
      step();
      chk("rel_start_ready", start_ready, 1);
      start_op(8'h09, 8'h04);
      wait_result(0);

      // Random traffic with random backpressure and idle gaps
      for (int n = 0; n < 30; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) step();
         start_op(W'($urandom), W'($urandom));
         wait_result(1);
      end

      step();
      step();
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
